// File: rtl/debounce_array_if.sv
// debounce_array_if
//   Button-path bundle between the raw front-panel pins and the debouncer.
//   master : drives btn_in, observes the debounced results (bench / pin side)
//   slave  : debouncer side, consumes btn_in and produces the results
//   Signals:
//     btn_in        raw asynchronous button levels, one bit per channel
//     db_level      debounced active-high level
//     press_pulse   one-cycle pulse on a debounced 0->1 transition
//     release_pulse one-cycle pulse on a debounced 1->0 transition
//     long_pulse    one-cycle pulse once a press has been held long enough
//     any_event     registered OR of all pulse bits, one cycle late
interface debounce_array_if #(
   parameter int N_CH = 5
);
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] db_level;
   logic [N_CH-1:0] press_pulse;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] long_pulse;
   logic            any_event;

   modport master (
      output btn_in,
      input  db_level, press_pulse, release_pulse, long_pulse, any_event
   );

   modport slave (
      input  btn_in,
      output db_level, press_pulse, release_pulse, long_pulse, any_event
   );
endinterface

// File: rtl/debounce_array.sv
// debounce_array
//   N-channel push-button debouncer. Each channel synchronises its raw pin,
//   requires STABLE_CNT consecutive sample ticks of a changed value before
//   accepting it, and emits press/release pulses coincident with the level
//   change. An optional hold counter emits a single long-press pulse.
//   Ports:
//     clk    system clock
//     reset  synchronous active-high reset, clears every flop
//     bus    debounce_array_if.slave (btn_in in; levels/pulses/any_event out)

// One channel: synchroniser, stability counter, level/pulse registers and
// the optional hold counter.
module debounce_lane #(
   parameter int CNT_W      = 16,
   parameter int STABLE_CNT = 6,
   parameter int LONG_CNT   = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_btn,
   input  logic i_inv,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);
   localparam logic [CNT_W-1:0] LP_STB_LAST = CNT_W'(STABLE_CNT - 1);

   logic             r_sync1, r_sync2;
   logic             r_level, r_press, r_release;
   logic [CNT_W-1:0] r_cnt;
   logic             w_diff, w_accept;

   assign w_diff   = r_sync2 ^ r_level;
   // Last window tick: the new sample has persisted long enough.
   assign w_accept = w_diff & i_tick & (r_cnt == LP_STB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn ^ i_inv;
         r_sync2   <= r_sync1;
         r_press   <= w_accept & r_sync2;
         r_release <= w_accept & ~r_sync2;
         if (w_accept) r_level <= r_sync2;
         // A matching sample restarts the window even between ticks, so a
         // single glitch back to the old level costs the whole window.
         if (!w_diff || w_accept) r_cnt <= '0;
         else if (i_tick)         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

   generate
      if (LONG_CNT > 0) begin : g_long
         localparam logic [CNT_W-1:0] LP_LONG      = CNT_W'(LONG_CNT);
         localparam logic [CNT_W-1:0] LP_LONG_LAST = CNT_W'(LONG_CNT - 1);
         logic [CNT_W-1:0] r_hold;
         logic             r_long;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_hold <= '0;
               r_long <= 1'b0;
            end else begin
               // Fires only on the step into LONG_CNT; saturation prevents repeats.
               r_long <= r_level & i_tick & (r_hold == LP_LONG_LAST);
               if (!r_level)                          r_hold <= '0;
               else if (i_tick && r_hold != LP_LONG)  r_hold <= r_hold + CNT_W'(1);
            end
         end
         assign o_long = r_long;
      end else begin : g_nolong
         assign o_long = 1'b0;
      end
   endgenerate
endmodule

module debounce_array #(
   parameter int              N_CH       = 5,
   parameter int              CNT_W      = 16,
   parameter int              STABLE_CNT = 6,
   parameter int              TICK_DIV   = 1,
   parameter int              LONG_CNT   = 0,
   parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
   input  logic             clk,
   input  logic             reset,
   debounce_array_if.slave  bus
);
   generate
      if (STABLE_CNT < 1) begin : g_err_stable
         $error("debounce_array: STABLE_CNT must be >= 1");
      end
      if ($clog2(STABLE_CNT + 1) > CNT_W || $clog2(LONG_CNT + 1) > CNT_W) begin : g_err_width
         $error("debounce_array: CNT_W too narrow for STABLE_CNT/LONG_CNT");
      end
   endgenerate

   logic            w_tick;
   logic [N_CH-1:0] w_inv;
   logic [N_CH-1:0] w_level, w_press, w_release, w_long;
   logic            r_any;

   assign w_inv = ACTIVE_LOW;

   // Shared sample tick; one prescaler serves every channel.
   generate
      if (TICK_DIV <= 1) begin : g_tick_every
         assign w_tick = 1'b1;
      end else begin : g_prescale
         localparam int             PW      = $clog2(TICK_DIV);
         localparam logic [PW-1:0]  LP_LAST = PW'(TICK_DIV - 1);
         logic [PW-1:0] r_pre;

         always_ff @(posedge clk) begin
            if (reset)                r_pre <= '0;
            else if (r_pre == LP_LAST) r_pre <= '0;
            else                      r_pre <= r_pre + PW'(1);
         end
         assign w_tick = (r_pre == LP_LAST);
      end
   endgenerate

   debounce_lane #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT)
   ) u_lane [N_CH-1:0] (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (w_tick),
      .i_btn     (bus.btn_in),
      .i_inv     (w_inv),
      .o_level   (w_level),
      .o_press   (w_press),
      .o_release (w_release),
      .o_long    (w_long)
   );

   always_ff @(posedge clk) begin
      if (reset) r_any <= 1'b0;
      else       r_any <= |(w_press | w_release | w_long);
   end

   assign bus.db_level      = w_level;
   assign bus.press_pulse   = w_press;
   assign bus.release_pulse = w_release;
   assign bus.long_pulse    = w_long;
   assign bus.any_event     = r_any;
endmodule

// File: tb/tb_debounce_array.sv
module tb_debounce_array;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // a: defaults, b: channel 4 active-low, c: slow tick with long-press
   debounce_array_if #(.N_CH(5)) if_a ();
   debounce_array_if #(.N_CH(5)) if_b ();
   debounce_array_if #(.N_CH(5)) if_c ();

   debounce_array #(.N_CH(5)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
   debounce_array #(.N_CH(5), .ACTIVE_LOW(5'b10000)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
   debounce_array #(.N_CH(5), .TICK_DIV(4), .STABLE_CNT(3), .LONG_CNT(5))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Outputs sampled and inputs driven 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [4:0] btn;
      logic [4:0] lvl;
      logic [4:0] prs;
      logic [4:0] rel;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [4:0] acc, acc2, b;
      int n, hit, cnt, p_edge;

      tbl[0] = '{btn: 5'b00001, lvl: 5'b00001, prs: 5'b00001, rel: 5'b00000};
      tbl[1] = '{btn: 5'b10101, lvl: 5'b10101, prs: 5'b10100, rel: 5'b00000};
      tbl[2] = '{btn: 5'b11111, lvl: 5'b11111, prs: 5'b01010, rel: 5'b00000};
      tbl[3] = '{btn: 5'b01010, lvl: 5'b01010, prs: 5'b00000, rel: 5'b10101};
      tbl[4] = '{btn: 5'b00000, lvl: 5'b00000, prs: 5'b00000, rel: 5'b01010};

      // ---- reset state (b holds its active-low pin "released" = 1) ----
      reset = 1'b1;
      if_a.btn_in = '0;
      if_b.btn_in = 5'b10000;
      if_c.btn_in = '0;
      repeat (3) step();
      chk("rst_a_level", 32'(if_a.db_level), 0);
      chk("rst_a_pulses", 32'(if_a.press_pulse | if_a.release_pulse | if_a.long_pulse), 0);
      chk("rst_a_any", 32'(if_a.any_event), 0);
      chk("rst_b_level", 32'(if_b.db_level), 0);
      chk("rst_c_level", 32'(if_c.db_level), 0);
      reset = 1'b0;
      repeat (2) step();
      chk("post_rst_a_level", 32'(if_a.db_level), 0);

      // ---- basic latency: level and pulse on the 8th edge (STABLE_CNT+2) ----
      if_a.btn_in = 5'b00001;
      acc = '0;
      repeat (7) begin
         step();
         acc |= if_a.db_level | if_a.press_pulse;
      end
      chk("lat_early", 32'(acc), 0);
      step();
      chk("lat_level", 32'(if_a.db_level), 32'b00001);
      chk("lat_press", 32'(if_a.press_pulse), 32'b00001);
      chk("lat_any_same_cycle", 32'(if_a.any_event), 0);
      step();
      chk("press_width", 32'(if_a.press_pulse), 0);
      chk("any_event_delayed", 32'(if_a.any_event), 1);
      step();
      chk("any_event_width", 32'(if_a.any_event), 0);
      if_a.btn_in = '0;
      repeat (12) step();
      chk("lat_released", 32'(if_a.db_level), 0);

      // ---- table: steady-state levels and the pulses seen on the way ----
      for (int i = 0; i < 5; i++) begin
         if_a.btn_in = tbl[i].btn;
         acc = '0;
         acc2 = '0;
         repeat (12) begin
            step();
            acc  |= if_a.press_pulse;
            acc2 |= if_a.release_pulse;
         end
         chk($sformatf("tbl%0d_level", i), 32'(if_a.db_level), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d_press", i), 32'(acc), 32'(tbl[i].prs));
         chk($sformatf("tbl%0d_release", i), 32'(acc2), 32'(tbl[i].rel));
      end

      // ---- bounce on channel 2: 3-cycle runs never reach the window ----
      b = '0;
      acc = '0;
      for (int k = 0; k < 10; k++) begin
         b[2] = ~b[2];
         if_a.btn_in = b;
         repeat (3) begin
            step();
            acc |= if_a.press_pulse | if_a.release_pulse | if_a.db_level;
         end
      end
      chk("bounce_quiet", 32'(acc), 0);
      if_a.btn_in = 5'b00100;
      cnt = 0;
      p_edge = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (if_a.press_pulse[2]) begin
            cnt++;
            if (p_edge == 0) p_edge = e;
         end
      end
      chk("bounce_press_edge", 32'(p_edge), 8);
      chk("bounce_press_count", 32'(cnt), 1);
      if_a.btn_in = '0;
      repeat (12) step();

      // ---- simultaneous press on channels 0/2/4 ----
      if_a.btn_in = 5'b10101;
      hit = 0;
      acc = '0;
      for (int e = 1; e <= 20 && hit == 0; e++) begin
         step();
         if (if_a.press_pulse != 0) begin
            hit = e;
            acc = if_a.press_pulse;
         end
      end
      chk("simul_edge", 32'(hit), 8);
      chk("simul_mask", 32'(acc), 32'b10101);
      if_a.btn_in = '0;
      repeat (12) step();

      // ---- reset 4 cycles into a window discards the partial count ----
      if_a.btn_in = 5'b00001;
      repeat (4) step();
      reset = 1'b1;
      acc = '0;
      repeat (2) begin
         step();
         acc |= if_a.press_pulse | if_a.release_pulse | if_a.db_level;
      end
      chk("rst_mid_quiet", 32'(acc), 0);
      reset = 1'b0;
      hit = 0;
      acc = '0;
      for (int e = 1; e <= 20 && hit == 0; e++) begin
         step();
         if (if_a.db_level[0]) begin
            hit = e;
            acc = if_a.press_pulse;
         end
      end
      chk("rst_mid_restart_edge", 32'(hit), 8);
      chk("rst_mid_press", 32'(acc), 32'b00001);

      // ---- active-low channel 4 on dut_b ----
      acc = '0;
      repeat (10) begin
         step();
         acc |= if_b.db_level | if_b.press_pulse | if_b.release_pulse;
      end
      chk("al_idle", 32'(acc), 0);
      if_b.btn_in = 5'b00000;
      hit = 0;
      for (int e = 1; e <= 20 && hit == 0; e++) begin
         step();
         if (if_b.press_pulse[4]) hit = e;
      end
      chk("al_press_edge", 32'(hit), 8);
      chk("al_level", 32'(if_b.db_level), 32'b10000);

      // ---- dut_c: tick every 4 clks, 3-tick window, long press at 5 ticks ----
      // Sample ticks count from edge 3; third tick lands on edge 11..14.
      if_c.btn_in = 5'b00010;
      hit = 0;
      for (int e = 1; e <= 40 && hit == 0; e++) begin
         step();
         if (if_c.press_pulse[1]) hit = e;
      end
      chk_rng("slow_press_edge", hit, 11, 14);
      hit = 0;
      for (int e = 1; e <= 40 && hit == 0; e++) begin
         step();
         if (if_c.long_pulse != 0) begin
            hit = e;
            acc = if_c.long_pulse;
         end
      end
      chk("long_edge", 32'(hit), 20);
      chk("long_mask", 32'(acc), 32'b00010);
      cnt = 0;
      repeat (40) begin
         step();
         if (if_c.long_pulse != 0) cnt++;
      end
      chk("long_no_repeat", 32'(cnt), 0);
      if_c.btn_in = '0;
      hit = 0;
      cnt = 0;
      for (int e = 1; e <= 40 && hit == 0; e++) begin
         step();
         if (if_c.long_pulse != 0) cnt++;
         if (if_c.release_pulse[1]) hit = e;
      end
      chk_rng("slow_release_edge", hit, 11, 14);
      chk("release_no_long", 32'(cnt), 0);

      // short press on dut_c: released before 5 ticks, so no long pulse
      if_c.btn_in = 5'b00010;
      hit = 0;
      for (int e = 1; e <= 40 && hit == 0; e++) begin
         step();
         if (if_c.press_pulse[1]) hit = e;
      end
      if_c.btn_in = '0;
      cnt = 0;
      repeat (30) begin
         step();
         if (if_c.long_pulse != 0) cnt++;
      end
      chk("short_press_seen", 32'(hit != 0), 1);
      chk("short_press_no_long", 32'(cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
